// File: rtl/ide_host_pkg.sv
// ide_host_pkg: shared FSM states, task-file register addresses and status bits for the IDE host initiator.
// The DMA states exist only when IDE_HOST_DMA_EN is defined.
package ide_host_pkg;
`ifdef IDE_HOST_DMA_EN
    typedef enum logic [2:0] {IDLE, SETUP, ACTIVE, RECOVER, DMA_WAIT, DMA_XFER} state_e;
`else
    typedef enum logic [1:0] {IDLE, SETUP, ACTIVE, RECOVER} state_e;
`endif
    localparam logic [2:0] REG_DATA     = 3'd0;
    localparam logic [2:0] REG_ERROR    = 3'd1;
    localparam logic [2:0] REG_FEATURES = 3'd1;
    localparam logic [2:0] REG_SECCNT   = 3'd2;
    localparam logic [2:0] REG_SECNR    = 3'd3;
    localparam logic [2:0] REG_CYLLO    = 3'd4;
    localparam logic [2:0] REG_CYLHI    = 3'd5;
    localparam logic [2:0] REG_DRVHEAD  = 3'd6;
    localparam logic [2:0] REG_STATUS   = 3'd7;
    localparam logic [2:0] REG_COMMAND  = 3'd7;
    localparam logic [2:0] REG_ALTSTAT  = 3'd6;
    localparam logic [2:0] REG_DEVCTRL  = 3'd6;
    localparam int STAT_BSY = 7;
    localparam int STAT_DRQ = 3;
endpackage

// File: rtl/ide_host_sync2.sv
// ide_host_sync2: two-flop synchroniser for asynchronous drive-side inputs, with a selectable reset value.
module ide_host_sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RST_VAL;
            q_o    <= RST_VAL;
        end else begin
            meta_q <= d_i;
            q_o    <= meta_q;
        end
    end
endmodule

// File: rtl/ide_host_initiator.sv
// ide_host_initiator: host-side IDE/ATAPI PIO register-cycle master driven by a req/ack command port.
// Define IDE_HOST_DMA_EN to add the multiword DMA engine and its ports.
module ide_host_initiator
    import ide_host_pkg::*;
#(
    parameter int T_SETUP       = 3,
    parameter int T_ACTIVE      = 8,
    parameter int T_RECOVERY    = 4,
    parameter int IORDY_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        req_write,
    input  logic        req_ctrl,
    input  logic [2:0]  req_addr,
    input  logic [15:0] req_wdata,
    output logic        ack,
    output logic        err,
    output logic [15:0] rdata,
    output logic        busy,
    output logic        intrq_s,
    output logic [2:0]  da,
    output logic        cs1fx_,
    output logic        cs3fx_,
    output logic        dior_,
    output logic        diow_,
    output logic [15:0] dd_out,
    output logic        dd_oe,
    input  logic [15:0] dd_in,
    input  logic        iordy,
    input  logic        intrq,
    input  logic        dmarq,
`ifdef IDE_HOST_DMA_EN
    input  logic        dma_start,
    input  logic [8:0]  dma_words,
    input  logic        dma_write,
    input  logic [15:0] dma_wdata,
    output logic        dma_wready,
    output logic        dma_rvalid,
    output logic        dma_done,
`endif
    output logic        dmack_
);
    localparam logic [7:0]  CNT_SETUP  = 8'(T_SETUP - 1);
    localparam logic [7:0]  CNT_ACTIVE = 8'(T_ACTIVE - 1);
    localparam logic [7:0]  CNT_RECOV  = 8'(T_RECOVERY - 1);
    localparam logic [15:0] WAIT_MAX   = 16'(IORDY_TIMEOUT);

    state_e      state_q;
    logic [7:0]  cnt_q;
    logic [15:0] wait_q;
    logic [15:0] rd_q;
    logic        write_q;
    logic        iordy_s;
    logic        dmarq_s;

    ide_host_sync2 #(.RST_VAL(1'b1)) u_sync_iordy (.clk(clk), .rst(rst), .d_i(iordy), .q_o(iordy_s));
    ide_host_sync2 #(.RST_VAL(1'b0)) u_sync_intrq (.clk(clk), .rst(rst), .d_i(intrq), .q_o(intrq_s));
    ide_host_sync2 #(.RST_VAL(1'b0)) u_sync_dmarq (.clk(clk), .rst(rst), .d_i(dmarq), .q_o(dmarq_s));

    assign busy = state_q != IDLE;

`ifdef IDE_HOST_DMA_EN
    logic       dma_q;
    logic [8:0] words_q;
`else
    logic unused_dmarq;
    assign unused_dmarq = dmarq_s;
    assign dmack_ = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wait_q  <= '0;
            rd_q    <= '0;
            write_q <= 1'b0;
            da      <= '0;
            cs1fx_  <= 1'b1;
            cs3fx_  <= 1'b1;
            dior_   <= 1'b1;
            diow_   <= 1'b1;
            dd_oe   <= 1'b0;
            dd_out  <= '0;
            ack     <= 1'b0;
            err     <= 1'b0;
            rdata   <= '0;
`ifdef IDE_HOST_DMA_EN
            dma_q      <= 1'b0;
            words_q    <= '0;
            dmack_     <= 1'b1;
            dma_wready <= 1'b0;
            dma_rvalid <= 1'b0;
            dma_done   <= 1'b0;
`endif
        end else begin
            ack <= 1'b0;
`ifdef IDE_HOST_DMA_EN
            dma_wready <= 1'b0;
            dma_rvalid <= 1'b0;
            dma_done   <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
`ifdef IDE_HOST_DMA_EN
                    if (dma_start) begin
                        dma_done <= dma_words == '0;
                        if (dma_words != '0) begin
                            words_q <= dma_words;
                            write_q <= dma_write;
                            dma_q   <= 1'b1;
                            state_q <= DMA_WAIT;
                        end
                    end else
`endif
                    // ack is still high in the cycle after completion, so a held req waits one more cycle
                    if (req && !ack) begin
                        write_q <= req_write;
                        da      <= req_addr;
                        cs1fx_  <= req_ctrl;
                        cs3fx_  <= !req_ctrl;
                        dd_oe   <= req_write;
                        if (req_write) dd_out <= req_wdata;
                        err     <= 1'b0;
                        cnt_q   <= CNT_SETUP;
                        state_q <= SETUP;
`ifdef IDE_HOST_DMA_EN
                        dma_q   <= 1'b0;
`endif
                    end
                end
                SETUP: begin
                    if (cnt_q != '0) cnt_q <= cnt_q - 8'd1;
                    else begin
                        dior_   <= write_q;
                        diow_   <= !write_q;
                        cnt_q   <= CNT_ACTIVE;
                        state_q <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (cnt_q != '0) cnt_q <= cnt_q - 8'd1;
                    else if (iordy_s || wait_q == WAIT_MAX) begin
                        dior_   <= 1'b1;
                        diow_   <= 1'b1;
                        err     <= !iordy_s;
                        wait_q  <= '0;
                        if (!write_q) rd_q <= dd_in;
`ifdef IDE_HOST_DMA_EN
                        if (dma_q && !write_q) begin
                            rdata      <= dd_in;
                            dma_rvalid <= 1'b1;
                        end
`endif
                        cnt_q   <= CNT_RECOV;
                        state_q <= RECOVER;
                    end else wait_q <= wait_q + 16'd1;
                end
                RECOVER: begin
                    if (cnt_q != '0) cnt_q <= cnt_q - 8'd1;
`ifdef IDE_HOST_DMA_EN
                    else if (dma_q) begin
                        words_q <= words_q - 9'd1;
                        if (words_q == 9'd1) begin
                            dmack_   <= 1'b1;
                            dd_oe    <= 1'b0;
                            dma_done <= 1'b1;
                            dma_q    <= 1'b0;
                            state_q  <= IDLE;
                        end else state_q <= DMA_WAIT;
                    end
`endif
                    else begin
                        ack     <= 1'b1;
                        cs1fx_  <= 1'b1;
                        cs3fx_  <= 1'b1;
                        dd_oe   <= 1'b0;
                        if (!write_q) rdata <= rd_q;
                        state_q <= IDLE;
                    end
                end
`ifdef IDE_HOST_DMA_EN
                // dmack_ stays low here between words, so a dropped dmarq simply pauses the burst
                DMA_WAIT: begin
                    if (dmarq_s) begin
                        dmack_  <= 1'b0;
                        dd_oe   <= write_q;
                        if (write_q) begin
                            dd_out     <= dma_wdata;
                            dma_wready <= 1'b1;
                        end
                        state_q <= DMA_XFER;
                    end
                end
                DMA_XFER: begin
                    dior_   <= write_q;
                    diow_   <= !write_q;
                    cnt_q   <= CNT_ACTIVE;
                    state_q <= ACTIVE;
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ide_host_initiator.sv
// tb_ide_host_initiator: directed table-driven bench for the PIO path of ide_host_initiator.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_ide_host_initiator;
    logic clk = 1'b0, rst = 1'b1;
    logic req = 1'b0, req_write = 1'b0, req_ctrl = 1'b0;
    logic [2:0] req_addr = '0;
    logic [15:0] req_wdata = '0, dd_in = '0;
    logic iordy = 1'b1, intrq = 1'b0, dmarq = 1'b0;
    logic ack, err, busy, intrq_s, cs1fx_, cs3fx_, dior_, diow_, dd_oe, dmack_;
    logic [15:0] rdata, dd_out;
    logic [2:0] da;
    int checks = 0, errors = 0;

    ide_host_initiator dut (
        .clk(clk), .rst(rst), .req(req), .req_write(req_write), .req_ctrl(req_ctrl),
        .req_addr(req_addr), .req_wdata(req_wdata), .ack(ack), .err(err), .rdata(rdata),
        .busy(busy), .intrq_s(intrq_s), .da(da), .cs1fx_(cs1fx_), .cs3fx_(cs3fx_),
        .dior_(dior_), .diow_(diow_), .dd_out(dd_out), .dd_oe(dd_oe), .dd_in(dd_in),
        .iordy(iordy), .intrq(intrq), .dmarq(dmarq), .dmack_(dmack_)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        w;
        logic        c;
        logic [2:0]  a;
        logic [15:0] wd;
        logic [15:0] din;
        logic [15:0] exp_rd;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One PIO cycle; counts are falling edges seen with each signal low, n_ack is the edge index of ack.
    task automatic run(input logic w, input logic c, input logic [2:0] a, input logic [15:0] wd,
                       output int n_ack, output int cs1_n, output int cs3_n, output int rd_n,
                       output int wr_n, output int oe_n, output int bad, output logic e);
        n_ack = 0; cs1_n = 0; cs3_n = 0; rd_n = 0; wr_n = 0; oe_n = 0; bad = 0; e = 1'b0;
        req = 1'b1; req_write = w; req_ctrl = c; req_addr = a; req_wdata = wd;
        for (int i = 1; i <= 600; i++) begin
            @(negedge clk);
            req = 1'b0;
            if (!cs1fx_) cs1_n++;
            if (!cs3fx_) cs3_n++;
            if (!dior_) rd_n++;
            if (!diow_) wr_n++;
            if (dd_oe) oe_n++;
            if (!cs1fx_ && !cs3fx_) bad++;
            if (dd_oe && (!w || dd_out !== wd)) bad++;
            if ((!cs1fx_ || !cs3fx_) && da !== a) bad++;
            if (ack) begin
                n_ack = i;
                e = err;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[7];
        int n_ack, cs1_n, cs3_n, rd_n, wr_n, oe_n, bad, a1, a2, gap, acks;
        logic e;
        tbl[0] = '{1'b0, 1'b0, 3'd7, 16'h0000, 16'h0050, 16'h0050};
        tbl[1] = '{1'b1, 1'b1, 3'd6, 16'h0004, 16'hDEAD, 16'h0050};
        tbl[2] = '{1'b0, 1'b0, 3'd0, 16'h0000, 16'h1234, 16'h1234};
        tbl[3] = '{1'b1, 1'b0, 3'd7, 16'h00EC, 16'h0000, 16'h1234};
        tbl[4] = '{1'b0, 1'b1, 3'd6, 16'h0000, 16'h00D0, 16'h00D0};
        tbl[5] = '{1'b0, 1'b0, 3'd3, 16'h0000, 16'hFFFF, 16'hFFFF};
        tbl[6] = '{1'b1, 1'b0, 3'd0, 16'hA5A5, 16'h0000, 16'hFFFF};

        repeat (3) @(negedge clk);
        chk("rst_cs1", cs1fx_, 1); chk("rst_cs3", cs3fx_, 1);
        chk("rst_dior", dior_, 1); chk("rst_diow", diow_, 1);
        chk("rst_dmack", dmack_, 1); chk("rst_da", da, 0);
        chk("rst_oe", dd_oe, 0); chk("rst_ddout", dd_out, 0);
        chk("rst_ack", ack, 0); chk("rst_err", err, 0);
        chk("rst_rdata", rdata, 0); chk("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);
        intrq = 1'b1;
        @(negedge clk);
        chk("intrq_lat1", intrq_s, 0);
        @(negedge clk);
        chk("intrq_lat2", intrq_s, 1);
        intrq = 1'b0;

        // nominal cycle: selects low 15 edges, strobe 8, ack on the 16th edge after req
        foreach (tbl[k]) begin
            dd_in = tbl[k].din;
            run(tbl[k].w, tbl[k].c, tbl[k].a, tbl[k].wd, n_ack, cs1_n, cs3_n, rd_n, wr_n, oe_n, bad, e);
            chk($sformatf("v%0d_ack", k), n_ack, 16);
            chk($sformatf("v%0d_cs1", k), cs1_n, tbl[k].c ? 0 : 15);
            chk($sformatf("v%0d_cs3", k), cs3_n, tbl[k].c ? 15 : 0);
            chk($sformatf("v%0d_dior", k), rd_n, tbl[k].w ? 0 : 8);
            chk($sformatf("v%0d_diow", k), wr_n, tbl[k].w ? 8 : 0);
            chk($sformatf("v%0d_oe", k), oe_n, tbl[k].w ? 15 : 0);
            chk($sformatf("v%0d_bus", k), bad, 0);
            chk($sformatf("v%0d_err", k), e, 0);
            chk($sformatf("v%0d_rdata", k), rdata, tbl[k].exp_rd);
            @(negedge clk);
        end

        // iordy low for 20 edges from the first edge after dior_ falls: strobe lasts 1 + 20 + 2 sync = 23
        dd_in = 16'h0BAD;
        req = 1'b1; req_write = 1'b0; req_ctrl = 1'b0; req_addr = 3'd1;
        n_ack = 0; rd_n = 0; e = 1'b0;
        a1 = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            req = 1'b0;
            if (!dior_) rd_n++;
            if (!dior_ && a1 == 0) begin
                a1 = i;
                iordy = 1'b0;
            end
            if (a1 != 0 && i == a1 + 20) iordy = 1'b1;
            if (ack) begin
                n_ack = i;
                e = err;
                break;
            end
        end
        chk("iordy_dior", rd_n, 23);
        chk("iordy_ack", n_ack, 31);
        chk("iordy_err", e, 0);
        chk("iordy_rdata", rdata, 16'h0BAD);
        @(negedge clk);

        // iordy stuck low: abort after IORDY_TIMEOUT extra active cycles
        iordy = 1'b0;
        dd_in = 16'h7777;
        run(1'b0, 1'b0, 3'd7, 16'h0, n_ack, cs1_n, cs3_n, rd_n, wr_n, oe_n, bad, e);
        chk("tmo_ack", n_ack, 16 + 255);
        chk("tmo_dior", rd_n, 8 + 255);
        chk("tmo_err", e, 1);
        iordy = 1'b1;
        repeat (3) @(negedge clk);

        // reset while a write strobe is active
        req = 1'b1; req_write = 1'b1; req_ctrl = 1'b1; req_addr = 3'd6; req_wdata = 16'h0002;
        a1 = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            req = 1'b0;
            if (!diow_) begin
                a1 = i;
                break;
            end
        end
        chk("rstmid_strobe_seen", a1, 4);
        @(negedge clk);
        chk("rstmid_oe_before", dd_oe, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_dior", dior_, 1); chk("rstmid_diow", diow_, 1);
        chk("rstmid_cs1", cs1fx_, 1); chk("rstmid_cs3", cs3fx_, 1);
        chk("rstmid_oe", dd_oe, 0); chk("rstmid_ack", ack, 0);
        rst = 1'b0;
        acks = 0;
        repeat (20) begin
            @(negedge clk);
            if (ack) acks++;
        end
        chk("rstmid_noack", acks, 0);
        dd_in = 16'h4321;
        run(1'b0, 1'b0, 3'd2, 16'h0, n_ack, cs1_n, cs3_n, rd_n, wr_n, oe_n, bad, e);
        chk("post_rst_ack", n_ack, 16);
        chk("post_rst_rdata", rdata, 16'h4321);
        @(negedge clk);

        // req held high: second ack 17 edges after the first, with idle cycles between
        dd_in = 16'h0050;
        req = 1'b1; req_write = 1'b0; req_ctrl = 1'b0; req_addr = 3'd7;
        a1 = 0; a2 = 0; gap = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (a1 != 0 && !busy) gap++;
            if (ack && a1 == 0) a1 = i;
            else if (ack) begin
                a2 = i;
                break;
            end
        end
        req = 1'b0;
        chk("b2b_first", a1, 16);
        chk("b2b_spacing", a2 - a1, 17);
        chk("b2b_idle_gap", gap >= 1, 1);
        repeat (3) @(negedge clk);
        chk("b2b_no_third", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
